// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared state encodings and default widths for the PRBS checker
package lfsr_checker_pkg;

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int DEF_N         = 8;
  localparam int DEF_LOCK_CNT  = 16;
  localparam int DEF_LOSS_WIN  = 64;
  localparam int DEF_LOSS_ERRS = 8;
  localparam int DEF_ERR_W     = 16;

endpackage

// File: rtl/lfsr_checker_tap.sv
// rtl/lfsr_checker_tap.sv - serial MSB-first tap-mask shift register
module lfsr_checker_tap #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         i_resetn,
  input  logic         i_load,
  input  logic         i_tap,
  output logic [N-1:0] o_tap_reg
);

  logic [N-1:0] r_tap_reg;

  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      r_tap_reg <= '0;
    end else if (i_load) begin
      r_tap_reg <= {r_tap_reg[N-2:0], i_tap};
    end
  end

  assign o_tap_reg = r_tap_reg;

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising serial PRBS checker with lock and error tracking
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int LOSS_WIN  = DEF_LOSS_WIN,
  parameter int LOSS_ERRS = DEF_LOSS_ERRS,
  parameter int ERR_W     = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_tap_reg,
  input  logic             tap_in,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int SEED_W = $clog2(N + 1);
  localparam int WIN_W  = $clog2(LOSS_WIN + 1);
  localparam int ERRS_W = $clog2(LOSS_ERRS + 1);

  logic [N-1:0]      w_tap_reg;
  logic [N-1:0]      r_hist;
  logic [1:0]        r_state;
  logic [SEED_W-1:0] r_seed_cnt;
  logic [7:0]        r_match_cnt;
  logic [WIN_W-1:0]  r_win_bits;
  logic [ERRS_W-1:0] r_win_errs;
  logic              r_locked;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_count;

  logic              w_predict;
  logic              w_mismatch;
  logic              w_err;
  logic              w_loss;
  logic [SEED_W-1:0] w_seed_inc;
  logic [7:0]        w_match_inc;
  logic [WIN_W-1:0]  w_win_bits_inc;
  logic [ERRS_W-1:0] w_win_errs_inc;

  lfsr_checker_tap #(.N(N)) u_tap (
    .clk       (clk),
    .i_resetn  (reset),
    .i_load    (load_tap_reg),
    .i_tap     (tap_in),
    .o_tap_reg (w_tap_reg)
  );

  assign w_predict      = ^(r_hist & w_tap_reg);
  assign w_mismatch     = bit_in ^ w_predict;
  // A tap-load cycle swallows the stream bit, so it can never raise an error.
  assign w_err          = bit_valid && !load_tap_reg && (r_state == ST_LOCKED) && w_mismatch;
  assign w_seed_inc     = r_seed_cnt + SEED_W'(1);
  assign w_match_inc    = r_match_cnt + 8'd1;
  assign w_win_bits_inc = r_win_bits + WIN_W'(1);
  assign w_win_errs_inc = r_win_errs + ERRS_W'(w_mismatch);
  assign w_loss         = w_err && (w_win_errs_inc == ERRS_W'(LOSS_ERRS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hist      <= '0;
      r_state     <= ST_SEED;
      r_seed_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_err;

      if (clear_err) begin
        r_err_count <= '0;
      end else if (w_err && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end

      if (load_tap_reg) begin
        r_state     <= ST_SEED;
        r_seed_cnt  <= '0;
        r_match_cnt <= '0;
        r_locked    <= 1'b0;
      end else if (bit_valid) begin
        case (r_state)
          ST_SEED: begin
            r_hist <= {r_hist[N-2:0], bit_in};
            if (w_seed_inc == SEED_W'(N)) begin
              r_state     <= ST_HUNT;
              r_seed_cnt  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_seed_cnt <= w_seed_inc;
            end
          end
          ST_HUNT: begin
            r_hist <= {r_hist[N-2:0], bit_in};
            if (w_mismatch) begin
              r_match_cnt <= '0;
            end else if (w_match_inc == 8'(LOCK_CNT)) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_match_cnt <= '0;
              r_win_bits  <= '0;
              r_win_errs  <= '0;
            end else begin
              r_match_cnt <= w_match_inc;
            end
          end
          ST_LOCKED: begin
            // Feed back the prediction so a corrupted bit cannot poison later predictions.
            r_hist <= {r_hist[N-2:0], w_predict};
            if (w_loss) begin
              r_state    <= ST_SEED;
              r_locked   <= 1'b0;
              r_seed_cnt <= '0;
              r_win_bits <= '0;
              r_win_errs <= '0;
            end else if (w_win_bits_inc == WIN_W'(LOSS_WIN)) begin
              r_win_bits <= '0;
              r_win_errs <= '0;
            end else begin
              r_win_bits <= w_win_bits_inc;
              r_win_errs <= w_win_errs_inc;
            end
          end
          default: begin
            r_state    <= ST_SEED;
            r_locked   <= 1'b0;
            r_seed_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side counterpart of the serial LFSR generator. It consumes the serial PRBS bit stream and self-synchronises from N received bits. It then predicts each next bit from a serially loaded tap mask, and reports lock status and bit errors. It sits at the far end of a link or loopback under test.

Parameters:
N, 8, register width; must match the generator.
LOCK_CNT, 16, consecutive correct predictions needed to declare lock (1..2^8-1).
LOSS_WIN, 64, observation window length in valid bits while locked.
LOSS_ERRS, 8, errors within one window that force loss of lock (1..LOSS_WIN).
ERR_W, 16, error counter width.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
load_tap_reg  in  1  shift tap_in into the tap mask this cycle.
tap_in  in  1  serial tap-mask bit.
bit_valid  in  1  bit_in is a stream bit this cycle.
bit_in  in  1  received stream bit.
clear_err  in  1  zero err_count.
locked  out  1  checker is locked.
err_pulse  out  1  one-cycle flag: the previous valid bit mismatched while locked.
err_count  out  ERR_W  saturating count of locked-state mismatches.

Behaviour:
- Reset: clk is the only clock; reset is synchronous and active-low.
  - reset=0 at an edge clears tap_reg, hist, all counters, locked, err_pulse and err_count to 0, and sets the state to SEED.
- Tap mask:
  - When load_tap_reg=1, tap_reg <= {tap_reg[N-2:0], tap_in} (MSB first).
  - A load cycle forces the state to SEED with the seed count at 0; err_count is unchanged.
  - If load_tap_reg and bit_valid are both 1, the tap load wins and the stream bit is dropped.
- History: hist[0] holds the most recent bit, hist[N-1] the oldest. The prediction is p = ^(hist & tap_reg).
- State machine (advances only on bit_valid=1 cycles):
  - SEED: hist <= {hist[N-2:0], bit_in}; no compare. After N bits, go to HUNT with the match counter at 0.
  - HUNT: compare bit_in with p, then shift bit_in into hist.
    - Match: increment the match counter; on reaching LOCK_CNT, go to LOCKED and clear the window counters.
    - Mismatch: clear the match counter and stay in HUNT; no err_count update.
  - LOCKED: compare bit_in with p, then shift p (not bit_in) into hist, so errors do not propagate.
    - Mismatch: err_pulse=1 on the next cycle; err_count increments, saturating at 2^ERR_W-1; the window error counter increments.
    - When the window bit counter reaches LOSS_WIN, both window counters clear.
    - If the window error counter reaches LOSS_ERRS, go to SEED on that same edge (the erroring bit still counts).
- locked = (state==LOCKED), registered.
  - It rises on the edge that completes the LOCK_CNT-th match.
  - It falls on the edge of the loss-triggering error.
- err_pulse is registered and high for exactly one cycle per erroring bit. It is 0 when bit_valid=0.
- clear_err has priority over a simultaneous increment: err_count becomes 0, and err_pulse still asserts.
- An all-zero tap_reg or all-zero stream is legal: prediction is constantly 0, and an all-zero stream locks.
- bit_valid gaps of any length freeze all state.

Decomposition:
- Shared include lfsr_defs.vh: state encodings (SEED=2'd0, HUNT=2'd1, LOCKED=2'd2) and default widths, shared with the generator bench.
- Reuse the existing `tap` serial tap-load module for tap_reg.
- Counters and the FSM stay inline.

Test Plan:
- Load taps 8'hB8 MSB-first. Drive 8 seed bits then a clean generator stream with gapless bit_valid → locked rises on valid bit 24 (8+16); err_count=0.
- After lock, flip one stream bit → err_pulse high exactly one cycle later, err_count=1, locked stays 1, following bits produce no further errors.
- After lock, inject 8 errors within 64 bits → locked falls on the 8th error; relock at 24 valid bits later with a clean stream; err_count=8.
- In HUNT, corrupt bit 5 of the match run → the match count restarts; lock needs 16 new consecutive matches.
- Assert clear_err on the same cycle as an error edge with err_count=5 → err_count=0, err_pulse=1. Also run ERR_W=4 with 20 errors → saturates at 15.
- Apply reset=0 mid-LOCKED with bit_valid high → next cycle locked=0, err_count=0, tap_reg=0, state SEED. Asserting load_tap_reg while locked → state SEED, err_count retained.
